// File: rtl/frontend_pkg.sv
// Shared types for the capture frontend: FSM states,
// sample width and the line descriptor bundle.
package frontend_pkg;

    localparam int RGB_W      = 8;
    localparam int SLOT_MAX_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CAPTURE,
        COMMIT,
        DROP
    } state_t;

    typedef struct packed {
        logic [SLOT_MAX_W-1:0] slot;
        logic [10:0]           ypos;
        logic [11:0]           len;
        logic                  fid;
        logic                  first;
    } line_desc_t;

endpackage

// File: rtl/linebuf_writer_if.sv
// RAM write bus plus line descriptor going to the
// scaler/line-doubler read side.
interface linebuf_writer_if #(
    parameter int SLOT_W = 2,
    parameter int X_W    = 11
);
    import frontend_pkg::*;

    logic                    wr_en_o;
    logic [SLOT_W+X_W-1:0]   wr_addr_o;
    logic [3*RGB_W-1:0]      wr_data_o;
    logic                    line_done_o;
    logic [SLOT_W-1:0]       line_slot_o;
    logic [10:0]             line_ypos_o;
    logic [11:0]             line_len_o;
    logic                    line_fid_o;
    logic                    line_first_o;

    modport master (
        output wr_en_o, wr_addr_o, wr_data_o,
        output line_done_o, line_slot_o,
        output line_ypos_o, line_len_o,
        output line_fid_o, line_first_o
    );

    modport slave (
        input wr_en_o, wr_addr_o, wr_data_o,
        input line_done_o, line_slot_o,
        input line_ypos_o, line_len_o,
        input line_fid_o, line_first_o
    );

endinterface

// File: rtl/linebuf_slot_ring.sv
// Write-slot pointer and occupancy counter for the line ring;
// the read pointer is implied by wr_slot - occupancy.
module linebuf_slot_ring #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              PCLK_i,
    input  logic              reset,
    input  logic              commit,
    input  logic              release_i,
    output logic [SLOT_W-1:0] wr_slot,
    output logic [SLOT_W:0]   occupancy,
    output logic              full
);

    logic rel_ok;

    assign rel_ok = release_i & (occupancy != '0);
    assign full   = (occupancy == (SLOT_W+1)'(NUM_SLOTS));

    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            wr_slot   <= '0;
            occupancy <= '0;
        end else begin
            if (commit)
                wr_slot <= wr_slot + 1'b1;
            if (commit && !rel_ok)
                occupancy <= occupancy + 1'b1;
            else if (!commit && rel_ok)
                occupancy <= occupancy - 1'b1;
        end
    end

endmodule

// File: rtl/linebuf_writer.sv
// Captures active lines into a ring of RAM slots and emits a
// descriptor per completed line; full ring drops whole lines.
module linebuf_writer
    import frontend_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS),
    parameter int X_W       = 11
) (
    input  logic             PCLK_i,
    input  logic             reset,
    input  logic             enable_i,
    input  logic [RGB_W-1:0] R_i,
    input  logic [RGB_W-1:0] G_i,
    input  logic [RGB_W-1:0] B_i,
    input  logic             DE_i,
    input  logic             datavalid_i,
    input  logic             VSYNC_i,
    input  logic             FID_i,
    input  logic [X_W-1:0]   xpos_i,
    input  logic [10:0]      ypos_i,
    input  logic             release_i,
    linebuf_writer_if.master wb,
    output logic [SLOT_W:0]  occupancy_o,
    output logic [7:0]       drop_cnt_o
);

    state_t            state_q;
    state_t            state_d;
    logic              vs_q;
    logic              vs_fall;
    logic              smp;
    logic              start;
    logic              wr_fire;
    logic              commit;
    logic              drop_hit;
    logic              full;
    logic              first_pend;
    logic [SLOT_W-1:0] wr_slot;
    logic [X_W-1:0]    last_x;
    logic [10:0]       ypos_q;
    logic              fid_q;
    line_desc_t        desc_q;
    logic              unused_slot_hi;

    assign smp     = DE_i & datavalid_i;
    assign vs_fall = vs_q & ~VSYNC_i;

    linebuf_slot_ring #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_ring (
        .PCLK_i    (PCLK_i),
        .reset     (reset),
        .commit    (commit),
        .release_i (release_i),
        .wr_slot   (wr_slot),
        .occupancy (occupancy_o),
        .full      (full)
    );

    always_ff @(posedge PCLK_i) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (vs_fall) state_d = WAIT;
                WAIT:    if (smp) state_d = full ? DROP : CAPTURE;
                CAPTURE: if (!DE_i) state_d = COMMIT;
                COMMIT:  state_d = WAIT;
                DROP:    if (!DE_i) state_d = WAIT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Line start and first write are decided on the same input cycle.
    always_comb begin
        start    = 1'b0;
        wr_fire  = 1'b0;
        commit   = 1'b0;
        drop_hit = 1'b0;
        if (enable_i) begin
            unique case (1'b1)
                state_q == WAIT: begin
                    start    = smp & ~full;
                    wr_fire  = smp & ~full;
                    drop_hit = smp & full;
                end
                state_q == CAPTURE: begin
                    wr_fire = smp;
                    commit  = ~DE_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            vs_q           <= 1'b1;
            first_pend     <= 1'b0;
            last_x         <= '0;
            ypos_q         <= '0;
            fid_q          <= 1'b0;
            desc_q         <= '0;
            drop_cnt_o     <= '0;
            wb.wr_en_o     <= 1'b0;
            wb.wr_addr_o   <= '0;
            wb.wr_data_o   <= '0;
            wb.line_done_o <= 1'b0;
        end else begin
            vs_q           <= VSYNC_i;
            wb.wr_en_o     <= wr_fire;
            wb.line_done_o <= commit;
            if (wr_fire) begin
                wb.wr_addr_o <= {wr_slot, xpos_i};
                wb.wr_data_o <= {R_i, G_i, B_i};
                last_x       <= xpos_i;
            end
            if (start) begin
                ypos_q <= ypos_i;
                fid_q  <= FID_i;
            end
            if (commit) begin
                desc_q <= '{
                    slot:  SLOT_MAX_W'(wr_slot),
                    ypos:  ypos_q,
                    len:   12'(last_x) + 12'd1,
                    fid:   fid_q,
                    first: first_pend
                };
            end
            // A new frame edge outranks the clear from a commit.
            if (vs_fall && (state_q != IDLE || enable_i))
                first_pend <= 1'b1;
            else if (commit)
                first_pend <= 1'b0;
            if (drop_hit && drop_cnt_o != 8'hFF)
                drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end

    assign wb.line_slot_o  = desc_q.slot[SLOT_W-1:0];
    assign wb.line_ypos_o  = desc_q.ypos;
    assign wb.line_len_o   = desc_q.len;
    assign wb.line_fid_o   = desc_q.fid;
    assign wb.line_first_o = desc_q.first;
    assign unused_slot_hi  = ^desc_q.slot;

endmodule

// File: tb/tb_linebuf_writer.sv
// Directed scoreboard bench for linebuf_writer.
// Writes and descriptors are checked at the falling edge.
module tb_linebuf_writer;

    localparam int NSL    = 4;
    localparam int SLOT_W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic [7:0]  R_i = '0, G_i = '0, B_i = '0;
    logic        DE_i = 1'b0;
    logic        datavalid_i = 1'b0;
    logic        VSYNC_i = 1'b1;
    logic        FID_i = 1'b0;
    logic [10:0] xpos_i = '0;
    logic [10:0] ypos_i = '0;
    logic        release_i = 1'b0;
    logic [SLOT_W:0] occupancy_o;
    logic [7:0]  drop_cnt_o;

    linebuf_writer_if #(.SLOT_W(SLOT_W), .X_W(11)) wb();

    linebuf_writer #(.NUM_SLOTS(NSL), .SLOT_W(SLOT_W), .X_W(11)) dut (
        .PCLK_i      (clk),
        .reset       (reset),
        .enable_i    (enable_i),
        .R_i         (R_i),
        .G_i         (G_i),
        .B_i         (B_i),
        .DE_i        (DE_i),
        .datavalid_i (datavalid_i),
        .VSYNC_i     (VSYNC_i),
        .FID_i       (FID_i),
        .xpos_i      (xpos_i),
        .ypos_i      (ypos_i),
        .release_i   (release_i),
        .wb          (wb),
        .occupancy_o (occupancy_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_wr[$];
    logic [63:0] exp_ds[$];

    int m_slot = 0;
    int m_occ = 0;
    int m_drop = 0;
    bit m_first = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (wb.wr_en_o) begin
            if (exp_wr.size() == 0)
                chk("wr_unexpected", 64'(wb.wr_en_o), 64'd0);
            else
                chk("wr_addr_data", {27'd0, wb.wr_addr_o, wb.wr_data_o},
                    exp_wr.pop_front());
        end
        if (wb.line_done_o) begin
            if (exp_ds.size() == 0)
                chk("desc_unexpected", 64'(wb.line_done_o), 64'd0);
            else
                chk("descriptor", {35'd0, 4'(wb.line_slot_o), wb.line_ypos_o,
                    wb.line_len_o, wb.line_fid_o, wb.line_first_o},
                    exp_ds.pop_front());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_occ"}, 64'(occupancy_o), 64'(m_occ));
        chk({tag, "_drop"}, 64'(drop_cnt_o), 64'(m_drop));
    endtask

    task automatic vsync_pulse();
        VSYNC_i = 1'b0;
        if (enable_i) m_first = 1'b1;
        cyc();
        VSYNC_i = 1'b1;
        cyc();
    endtask

    task automatic do_release();
        release_i = 1'b1;
        if (m_occ > 0) m_occ--;
        cyc();
        release_i = 1'b0;
        cyc();
    endtask

    task automatic drive_smp(input int x, input bit wr);
        logic [23:0] d;
        d = 24'($urandom);
        {R_i, G_i, B_i} = d;
        xpos_i = 11'(x);
        datavalid_i = 1'b1;
        if (wr) exp_wr.push_back({27'd0, SLOT_W'(m_slot), 11'(x), d});
        cyc();
    endtask

    task automatic send_line(input int yp, input int x0, input int n,
                             input bit skip, input bit rel);
        bit wr;
        bit fid;
        bit rel_ok;
        wr = (m_occ < NSL);
        if (!wr && m_drop < 255) m_drop++;
        fid = 1'($urandom_range(0, 1));
        DE_i = 1'b1;
        ypos_i = 11'(yp);
        FID_i = fid;
        for (int i = 0; i < n; i++) begin
            drive_smp(x0 + i, wr);
            if (skip) begin
                datavalid_i = 1'b0;
                xpos_i = ~xpos_i;
                R_i = ~R_i;
                cyc();
            end
        end
        DE_i = 1'b0;
        datavalid_i = 1'b0;
        release_i = rel;
        rel_ok = rel && (m_occ > 0);
        if (wr) begin
            exp_ds.push_back({35'd0, 4'(m_slot), 11'(yp), 12'(x0 + n), fid, m_first});
            m_slot = (m_slot + 1) % NSL;
            m_first = 1'b0;
            m_occ++;
        end
        if (rel_ok) m_occ--;
        cyc();
        release_i = 1'b0;
        cyc();
        chk("line_occ", 64'(occupancy_o), 64'(m_occ));
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_wr_en", 64'(wb.wr_en_o), 64'd0);
        chk("rst_addr", 64'(wb.wr_addr_o), 64'd0);
        chk("rst_data", 64'(wb.wr_data_o), 64'd0);
        chk("rst_done", 64'(wb.line_done_o), 64'd0);
        chk("rst_desc", {35'd0, 4'(wb.line_slot_o), wb.line_ypos_o,
            wb.line_len_o, wb.line_fid_o, wb.line_first_o}, 64'd0);
        check_state("rst");
        reset = 1'b0;
        cyc();

        // Samples before enable and VSYNC are ignored.
        DE_i = 1'b1;
        drive_smp(3, 1'b0);
        DE_i = 1'b0;
        datavalid_i = 1'b0;
        cyc();
        enable_i = 1'b1;
        cyc();
        vsync_pulse();

        send_line(10, 0, 720, 1'b0, 1'b0);
        send_line(11, 0, 360, 1'b1, 1'b0);
        check_state("two_lines");

        // Commit and release in the same cycle at occupancy 2.
        send_line(12, 0, 20, 1'b0, 1'b1);
        check_state("commit_rel");
        do_release();
        do_release();
        do_release();
        check_state("rel_empty");

        vsync_pulse();
        send_line(20, 0, 16, 1'b0, 1'b0);
        send_line(21, 2040, 8, 1'b0, 1'b0);
        send_line(22, 0, 16, 1'b1, 1'b0);
        send_line(23, 5, 16, 1'b0, 1'b0);
        send_line(24, 0, 16, 1'b0, 1'b0);
        check_state("full_ring");
        do_release();
        send_line(25, 0, 12, 1'b0, 1'b0);
        check_state("after_rel");

        // Abort mid-line by dropping enable.
        do_release();
        DE_i = 1'b1;
        ypos_i = 11'd30;
        for (int x = 0; x < 100; x++) drive_smp(x, 1'b1);
        enable_i = 1'b0;
        xpos_i = 11'd100;
        cyc();
        DE_i = 1'b0;
        datavalid_i = 1'b0;
        cyc();
        cyc();
        check_state("abort");
        enable_i = 1'b1;
        cyc();
        vsync_pulse();
        send_line(31, 0, 40, 1'b0, 1'b0);
        check_state("re_enable");

        for (int i = 0; i < 300; i++) send_line(40, 0, 1, 1'b0, 1'b0);
        check_state("saturate");

        // Reset mid-line: no further write and no descriptor.
        do_release();
        DE_i = 1'b1;
        ypos_i = 11'd50;
        for (int x = 0; x < 10; x++) drive_smp(x, 1'b1);
        reset = 1'b1;
        drive_smp(10, 1'b0);
        chk("midrst_wr_en", 64'(wb.wr_en_o), 64'd0);
        chk("midrst_done", 64'(wb.line_done_o), 64'd0);
        m_occ = 0;
        m_drop = 0;
        m_slot = 0;
        m_first = 1'b0;
        check_state("midrst");
        DE_i = 1'b0;
        datavalid_i = 1'b0;
        reset = 1'b0;
        cyc();
        vsync_pulse();
        send_line(60, 0, 8, 1'b0, 1'b0);
        cyc();
        cyc();

        chk("wr_pending", 64'(exp_wr.size()), 64'd0);
        chk("desc_pending", 64'(exp_ds.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
